// File: rtl/mux_4x1_scanner_pkg.sv
// Shared types and constants for the 4x1 mux scanner.
// Channel count, channel index type and FSM state encoding.
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic [1:0] {IDLE, SCAN, OUT} scan_state_t;
  typedef logic [CH_W-1:0] ch_idx_t;

  // Dwell counter width: $clog2(DWELL+1), never below one bit.
  function automatic int dwell_cnt_w(input int dwell);
    int w;
    w = $clog2(dwell + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux_4x1_scanner_dwell_timer.sv
// Dwell timer: a reloadable down-counter that flags the last cycle of a dwell.
// tc is high while the counter sits at zero, i.e. on the final cycle of the dwell.
module dwell_timer #(
  parameter int DWELL = 2,
  parameter int W     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] RELOAD = W'(DWELL - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= RELOAD;
    end else if (en) begin
      cnt_q <= tc ? RELOAD : cnt_q - 1'b1;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/mux_4x1_scanner.sv
// Scanner FSM: steps the mux selects through channels 0..3, samples f at the
// end of each dwell and offers the assembled 4-bit frame on a valid/ready port.
module mux_4x1_scanner
  import mux_scan_pkg::*;
#(
  parameter int DWELL      = 2,
  parameter int CONTINUOUS = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        f,
  output logic        s0,
  output logic        s1,
  output logic        busy,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [3:0]  frame,
  output scan_state_t dbg_state
);

  localparam int      CNT_W   = dwell_cnt_w(DWELL);
  localparam ch_idx_t CH_LAST = ch_idx_t'(NUM_CH - 1);

  // Handshake: frame is transferred on a rising edge where frame_valid and
  // frame_ready are both high; frame_valid and frame never change before it.
  scan_state_t state_q, state_d;
  ch_idx_t     ch_q, ch_d;
  logic [2:0]  cap_q, cap_d;
  logic [3:0]  frame_q, frame_d;
  logic        tmr_load, tmr_en, tmr_tc;

  dwell_timer #(
    .DWELL (DWELL),
    .W     (CNT_W)
  ) u_dwell_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .en    (tmr_en),
    .tc    (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      cap_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cap_q   <= cap_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cap_d    = cap_q;
    frame_d  = frame_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SCAN;
          ch_d     = '0;
          tmr_load = 1'b1;
        end
      end
      SCAN: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          // The last channel goes straight into the frame, not the buffer.
          if (ch_q == CH_LAST) begin
            frame_d = {f, cap_q};
            state_d = OUT;
            ch_d    = '0;
          end else begin
            case (ch_q)
              2'd0:    cap_d[0] = f;
              2'd1:    cap_d[1] = f;
              2'd2:    cap_d[2] = f;
              default: ;
            endcase
            ch_d = ch_idx_t'(ch_q + 1'b1);
          end
        end
      end
      OUT: begin
        if (frame_ready) begin
          ch_d = '0;
          if ((CONTINUOUS != 0) || start) begin
            state_d  = SCAN;
            tmr_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s0          = ch_q[1];
  assign s1          = ch_q[0];
  assign busy        = (state_q == SCAN);
  assign frame_valid = (state_q == OUT);
  assign frame       = frame_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mux_4x1_scanner.sv
// Directed bench for mux_4x1_scanner: three instances cover DWELL=2 one-shot,
// DWELL=1 continuous and DWELL=1 with start held; the 4x1 mux is modelled inline.
module tb_mux_4x1_scanner;
  import mux_scan_pkg::*;

  logic clk;
  logic rst_n;

  // Instance A: DWELL=2, CONTINUOUS=0
  logic start_a, ready_a, s0_a, s1_a, busy_a, valid_a, f_a;
  logic [3:0] x_a, frame_a;
  scan_state_t st_a;
  // Instance B: DWELL=1, CONTINUOUS=1
  logic start_b, ready_b, s0_b, s1_b, busy_b, valid_b, f_b;
  logic [3:0] x_b, frame_b;
  scan_state_t st_b;
  // Instance C: DWELL=1, CONTINUOUS=0
  logic start_c, ready_c, s0_c, s1_c, busy_c, valid_c, f_c;
  logic [3:0] x_c, frame_c;
  scan_state_t st_c;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  // 4x1 mux: {s0,s1} is the channel index.
  assign f_a = x_a[{s0_a, s1_a}];
  assign f_b = x_b[{s0_b, s1_b}];
  assign f_c = x_c[{s0_c, s1_c}];

  mux_4x1_scanner #(.DWELL(2), .CONTINUOUS(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .f(f_a), .s0(s0_a), .s1(s1_a),
    .busy(busy_a), .frame_valid(valid_a), .frame_ready(ready_a), .frame(frame_a),
    .dbg_state(st_a));
  mux_4x1_scanner #(.DWELL(1), .CONTINUOUS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .f(f_b), .s0(s0_b), .s1(s1_b),
    .busy(busy_b), .frame_valid(valid_b), .frame_ready(ready_b), .frame(frame_b),
    .dbg_state(st_b));
  mux_4x1_scanner #(.DWELL(1), .CONTINUOUS(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .f(f_c), .s0(s0_c), .s1(s1_c),
    .busy(busy_c), .frame_valid(valid_c), .frame_ready(ready_c), .frame(frame_c),
    .dbg_state(st_c));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [3:0] obs);
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) chk(tag, obs, exp_q.pop_front());
  endtask

  // Drive a start pulse on A and run to the end of the scan (edge E8).
  task automatic run_scan_a(input string tag, input logic [3:0] x);
    x_a = x;
    exp_q.push_back(x);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (7) step();
    chk({tag, "_valid_pre"}, valid_a, 0);
    step();
    chk({tag, "_valid"}, valid_a, 1);
    chk({tag, "_busy_out"}, busy_a, 0);
    sb_check({tag, "_frame"}, frame_a);
  endtask

  task automatic handshake_a(input string tag);
    ready_a = 1'b1;
    step();
    ready_a = 1'b0;
    chk({tag, "_valid_drop"}, valid_a, 0);
    chk({tag, "_idle"}, st_a, IDLE);
  endtask

  initial begin
    rst_n = 1'b0;
    {start_a, ready_a, start_b, ready_b, start_c, ready_c} = '0;
    x_a = '0; x_b = '0; x_c = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_sel", {s0_a, s1_a}, 0);
    chk("rst_frame", frame_a, 0);
    chk("rst_state", st_a, IDLE);
    chk("rst_state_b", st_b, IDLE);

    // Basic scan, DWELL=2, x=1010, with select sequence checked edge by edge
    x_a = 4'b1010;
    exp_q.push_back(4'b1010);
    start_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      start_a = 1'b0;
      chk($sformatf("scan_sel_%0d", k), {s0_a, s1_a}, k / 2);
      chk($sformatf("scan_busy_%0d", k), busy_a, 1);
    end
    step();
    chk("scan_valid", valid_a, 1);
    chk("scan_busy_out", busy_a, 0);
    chk("scan_sel_out", {s0_a, s1_a}, 0);
    sb_check("scan_frame", frame_a);

    // Backpressure: frame held, start pulses ignored
    for (int k = 0; k < 5; k++) begin
      start_a = (k % 2 == 0);
      step();
      chk($sformatf("bp_valid_%0d", k), valid_a, 1);
      chk($sformatf("bp_frame_%0d", k), frame_a, 4'b1010);
      chk($sformatf("bp_state_%0d", k), st_a, OUT);
    end
    start_a = 1'b0;
    handshake_a("bp");
    chk("bp_frame_hold", frame_a, 4'b1010);

    // Per-channel sampling: x1 is 0 in dwell cycle 0 and 1 in dwell cycle 1
    x_a = 4'b0000;
    exp_q.push_back(4'b0010);
    start_a = 1'b1;
    step();                 // E0
    start_a = 1'b0;
    repeat (2) step();      // E1, E2: channel 1 now selected
    chk("samp_sel1", {s0_a, s1_a}, 1);
    step();                 // E3
    x_a[1] = 1'b1;
    step();                 // E4: capture of channel 1
    x_a[1] = 1'b0;
    repeat (4) step();      // E5..E8
    chk("samp_valid", valid_a, 1);
    sb_check("samp_frame", frame_a);
    handshake_a("samp");

    // Reset mid-scan while channel 2 is selected
    x_a = 4'b1111;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (4) step();
    chk("mid_sel2", {s0_a, s1_a}, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", {s0_a, s1_a}, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_valid", valid_a, 0);
    chk("mid_rst_state", st_a, IDLE);
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_state", st_a, IDLE);
    chk("post_rst_frame", frame_a, 0);
    run_scan_a("post_rst", 4'b0101);
    handshake_a("post_rst");

    // Continuous mode on B: a frame every 5 edges, busy low during OUT
    x_b = 4'b0110;
    ready_b = 1'b1;
    repeat (3) exp_q.push_back(4'b0110);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      step();
      if (e % 5 == 4) begin
        chk($sformatf("cont_valid_%0d", e), valid_b, 1);
        chk($sformatf("cont_busy_out_%0d", e), busy_b, 0);
        sb_check($sformatf("cont_frame_%0d", e), frame_b);
      end else begin
        chk($sformatf("cont_valid_low_%0d", e), valid_b, 0);
        chk($sformatf("cont_busy_%0d", e), busy_b, 1);
      end
    end
    ready_b = 1'b0;
    chk("cont_sb_drained", exp_q.size(), 0);

    // Start held high on C: back-to-back scans, OUT lasts one cycle
    x_c = 4'b1001;
    ready_c = 1'b1;
    start_c = 1'b1;
    step();
    for (int e = 1; e <= 10; e++) begin
      step();
      if (e % 5 == 4) begin
        chk($sformatf("held_valid_%0d", e), valid_c, 1);
        chk($sformatf("held_frame_%0d", e), frame_c, 4'b1001);
      end else begin
        chk($sformatf("held_valid_low_%0d", e), valid_c, 0);
        chk($sformatf("held_busy_%0d", e), busy_c, 1);
      end
    end
    start_c = 1'b0;
    repeat (5) step();
    chk("held_idle", st_c, IDLE);
    chk("held_frame_hold", frame_c, 4'b1001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
